// File: rtl/fp_recode_pkg.sv
// Shared constants and helpers for FN -> recFN recoding.
package fp_recode_pkg;
  localparam int EXP_WIDTH_DEF = 11;
  localparam int SIG_WIDTH_DEF = 53;
  localparam int TAG_WIDTH_DEF = 5;

  // Top three recoded exponent bits that mark special classes.
  localparam logic [2:0] REC_ZERO = 3'b000;
  localparam logic [2:0] REC_INF  = 3'b110;
  localparam logic [2:0] REC_NAN  = 3'b111;

  // Recoding bias term: 2^(exp_w-1), i.e. 0x400 for doubles.
  function automatic int rec_bias(input int exp_w);
    return 1 << (exp_w - 1);
  endfunction

  // Class field of the recoded exponent from the raw adjusted exponent top bits.
  function automatic logic [2:0] rec_exp_code(input logic is_zero, input logic is_nan,
                                              input logic [2:0] adj_top);
    if (is_zero) return REC_ZERO;
    if (is_nan)  return REC_NAN;
    return adj_top;
  endfunction
endpackage

// File: rtl/lzc_sat.sv
// Leading-zero counter with an upper saturation value.
module lzc_sat #(
  parameter int W   = 52,
  parameter int SAT = W - 1,
  localparam int CW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);
  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    cnt_o = CW'(SAT);
    for (int i = 0; i < W; i++)
      if (vec_i[i] && (W - 1 - i) < SAT) cnt_o = CW'(W - 1 - i);
  end
endmodule

// File: rtl/rec_fn_from_fn_pipe.sv
// Two-stage FN -> recFN converter with valid/ready handshakes, flush and a sideband tag.
module rec_fn_from_fn_pipe
  import fp_recode_pkg::*;
#(
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int SIG_WIDTH = SIG_WIDTH_DEF,
  parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_flush,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [EXP_WIDTH+SIG_WIDTH-1:0] io_in_bits,
  input  logic [TAG_WIDTH-1:0]           io_in_tag,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
  output logic [EXP_WIDTH+SIG_WIDTH:0]   io_out_bits,
  output logic [TAG_WIDTH-1:0]           io_out_tag
);
  localparam int FW = SIG_WIDTH - 1;
  localparam int XW = EXP_WIDTH + 1;
  localparam int NW = $clog2(FW);
  localparam logic [XW-1:0] BIAS = XW'(rec_bias(EXP_WIDTH));

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp;
    logic [FW-1:0]        fract;
    logic [NW-1:0]        nd;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [EXP_WIDTH+SIG_WIDTH:0] bits;
    logic [TAG_WIDTH-1:0]         tag;
  } s2_t;

  logic [2:1]    vld_q, vld_d;
  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic          s1_adv, in_fire, s2_load;
  logic [NW-1:0] nd_in;

  lzc_sat #(.W(FW), .SAT(FW - 1)) u_lzc (
    .vec_i (io_in_bits[FW-1:0]),
    .cnt_o (nd_in)
  );

  assign s1_adv      = ~vld_q[2] | io_out_ready;
  assign io_in_ready = ~vld_q[1] | s1_adv;
  assign in_fire     = io_in_valid & io_in_ready;
  assign s2_load     = vld_q[1] & s1_adv;

  // Flush overrides everything, including an input accepted this cycle.
  always_comb begin
    vld_d = vld_q;
    if (io_in_ready) vld_d[1] = io_in_valid;
    if (s1_adv)      vld_d[2] = vld_q[1];
    if (io_flush)    vld_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  always_ff @(posedge clock) begin
    if (in_fire) s1_q <= s1_d;
    if (s2_load) s2_q <= s2_d;
  end

  assign s1_d = {io_in_bits, nd_in, io_in_tag};

  logic              is_zero_exp, is_zero_fract, is_zero, is_special, is_nan;
  logic [FW-1:0]     sub_fract;
  logic [XW-1:0]     exp_src, adj_exp;
  logic [2:0]        code;

  // Subnormals are normalised so the leading one becomes the hidden bit.
  always_comb begin
    is_zero_exp   = s1_q.exp == '0;
    is_zero_fract = s1_q.fract == '0;
    sub_fract     = FW'({s1_q.fract, 1'b0} << s1_q.nd);
    exp_src       = is_zero_exp ? ~XW'(s1_q.nd) : XW'(s1_q.exp);
    adj_exp       = exp_src + (BIAS | (is_zero_exp ? XW'(2) : XW'(1)));
    is_zero       = is_zero_exp & is_zero_fract;
    is_special    = adj_exp[XW-1 -: 2] == REC_INF[2:1];
    is_nan        = is_special & ~is_zero_fract;
    code          = rec_exp_code(is_zero, is_nan, adj_exp[XW-1 -: 3]);
    s2_d.bits     = {s1_q.sign, code, adj_exp[XW-4:0], is_zero_exp ? sub_fract : s1_q.fract};
    s2_d.tag      = s1_q.tag;
  end

  assign io_out_valid = vld_q[2];
  assign io_out_bits  = s2_q.bits;
  assign io_out_tag   = s2_q.tag;
endmodule
